key_search_datapath: RTL

- Datapath stage directly downstream of the key-search control FSM. It consumes the FSM's up, en1 and en2 strobes and returns keyFound to it.
- Holds the candidate-key counter and drives the candidate key to the external DES core.
- Compares the core's ciphertext against the target, latches the winning key, and reports found or exhausted status.
- The DES core itself is external and combinational, so cipher_in is valid in the same cycle as des_key.

---
 rtl/key_search_datapath.sv | 130 +++++++++++++
 1 files changed

// File: rtl/key_search_datapath.sv
// Key-search datapath: candidate-key counter, DES key formatting, match compare and result latch.
// Optional KEY_PARITY_EN sets each des_key byte to odd parity; otherwise the parity bit is 0.
module key_search_datapath #(
    parameter int KEY_W = 56,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             up,
    input  logic             en1,
    input  logic             en2,
    input  logic [KEY_W-1:0] key_lo,
    input  logic [KEY_W-1:0] key_hi,
    input  logic [63:0]      target_cipher,
    input  logic [63:0]      cipher_in,
    output logic [63:0]      des_key,
    output logic             keyFound,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] found_key,
    output logic [CNT_W-1:0] attempts
);

    localparam int NBYTES = KEY_W / 7;
    localparam logic [KEY_W-1:0] KEY_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [KEY_W-1:0] key_cnt_q, key_cnt_d;
    logic             primed_q, primed_d;
    logic             start_q, start_d;
    logic             found_q, found_d;
    logic             exhausted_q, exhausted_d;
    logic [KEY_W-1:0] found_key_q, found_key_d;
    logic [CNT_W-1:0] attempts_q, attempts_d;

    logic start_rise;
    logic match;
    logic last;
    logic cnt_at_max;

    assign start_rise = start && !start_q;
    assign match      = (cipher_in == target_cipher);
    assign cnt_at_max = (key_cnt_q == KEY_MAX);
    assign last       = (key_cnt_q == key_hi) || cnt_at_max;
    assign keyFound   = primed_q && (match || last);

    // Byte 0 is the most significant byte and carries the top 7 key bits.
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_byte
        if (gi < NBYTES) begin : g_used
            logic [6:0] key_bits;
            assign key_bits = key_cnt_q[KEY_W-1-7*gi -: 7];
`ifdef KEY_PARITY_EN
            assign des_key[63-8*gi -: 8] = {key_bits, ~(^key_bits)};
`else
            assign des_key[63-8*gi -: 8] = {key_bits, 1'b0};
`endif
        end else begin : g_unused
            assign des_key[63-8*gi -: 8] = 8'h00;
        end
    end

    always_comb begin
        start_d     = start;
        key_cnt_d   = key_cnt_q;
        primed_d    = primed_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        found_key_d = found_key_q;
        attempts_d  = attempts_q;

        // The first up only arms the compare, so key_lo itself is the first candidate.
        if (!start) begin
            key_cnt_d = key_lo;
            primed_d  = 1'b0;
        end else if (up) begin
            if (!primed_q) begin
                primed_d = 1'b1;
            end else if (!cnt_at_max) begin
                key_cnt_d = key_cnt_q + KEY_W'(1);
            end
        end

        if (start_rise) begin
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            found_key_d = '0;
            attempts_d  = '0;
        end else begin
            if (en1 && (attempts_q != CNT_MAX)) begin
                attempts_d = attempts_q + CNT_W'(1);
            end
            if (en2 && !found_q && !exhausted_q) begin
                if (match) begin
                    found_d     = 1'b1;
                    found_key_d = key_cnt_q;
                end else begin
                    exhausted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_cnt_q   <= '0;
            primed_q    <= 1'b0;
            start_q     <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            found_key_q <= '0;
            attempts_q  <= '0;
        end else begin
            key_cnt_q   <= key_cnt_d;
            primed_q    <= primed_d;
            start_q     <= start_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            found_key_q <= found_key_d;
            attempts_q  <= attempts_d;
        end
    end

    assign found     = found_q;
    assign exhausted = exhausted_q;
    assign found_key = found_key_q;
    assign attempts  = attempts_q;

endmodule
